cpu_controller: RTL

Multi-cycle control FSM for the ARM32 core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder, register file, ALU/shifter and unified memory port. It consumes the decoded opcode, condition field, status-enable bit and NZCV flags, and drives every datapath enable and select. It owns the memory request handshake and halting.

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/cpu_controller_cond_eval.sv | 35 +++
 rtl/cpu_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the ARM32 multi-cycle controller:
// FSM states, opcode classes, datapath select codes and condition codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_WB2, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_CMP, CLS_NOP, CLS_HALT, CLS_B, CLS_BL, CLS_BX, CLS_BLX,
    CLS_LDR, CLS_STR
  } op_class_e;

  localparam logic [1:0] SEL_PC_4   = 2'b00;
  localparam logic [1:0] SEL_PC_BR  = 2'b01;
  localparam logic [1:0] SEL_PC_RM  = 2'b10;
  localparam logic [1:0] SEL_PC_RST = 2'b11;

  localparam logic [1:0] RF_DST_RD = 2'b00;
  localparam logic [1:0] RF_DST_RN = 2'b01;
  localparam logic [1:0] RF_DST_LR = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [3:0] CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010,
                         CC_CC = 4'b0011, CC_MI = 4'b0100, CC_PL = 4'b0101,
                         CC_VS = 4'b0110, CC_VC = 4'b0111, CC_HI = 4'b1000,
                         CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
                         CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110,
                         CC_NV = 4'b1111;

  localparam logic [6:0] OP_NOP  = 7'b0100000;
  localparam logic [6:0] OP_HALT = 7'b0101010;

  // Unlisted encodings fall through to NOP so they simply advance the PC.
  function automatic op_class_e classify(input logic [6:0] op);
    op_class_e cls;
    cls = CLS_NOP;
    casez (op)
      7'b00?????, 7'b011????: cls = (op[4:0] == 5'b11010) ? CLS_CMP : CLS_ALU;
      7'b1001000:             cls = CLS_B;
      7'b1001010:             cls = CLS_BL;
      7'b1001001:             cls = CLS_BX;
      7'b1001011:             cls = CLS_BLX;
      7'b1000???, 7'b110????: cls = CLS_LDR;
      7'b111????:             cls = CLS_STR;
      default:                cls = (op == OP_HALT) ? CLS_HALT : CLS_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// ARM condition-code evaluation against the current {N,Z,C,V} flags.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status_nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = status_nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ:   pass = z;
      CC_NE:   pass = !z;
      CC_CS:   pass = c;
      CC_CC:   pass = !c;
      CC_MI:   pass = n;
      CC_PL:   pass = !n;
      CC_VS:   pass = v;
      CC_VC:   pass = !v;
      CC_HI:   pass = c && !z;
      CC_LS:   pass = !c || z;
      CC_GE:   pass = (n == v);
      CC_LT:   pass = (n != v);
      CC_GT:   pass = !z && (n == v);
      CC_LE:   pass = z || (n != v);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable, select and the memory handshake.
module cpu_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic [3:0] cond,
  input  logic       en_status,
  input  logic [3:0] status_nzcv,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       load_ir,
  output logic       load_pc,
  output logic [1:0] sel_pc,
  output logic       en_A,
  output logic       en_B,
  output logic       en_S,
  output logic       en_C,
  output logic       load_flags,
  output logic       w_en_rf,
  output logic [1:0] rf_dst_sel,
  output logic [1:0] wb_sel,
  output logic       waiting,
  output logic       halted
);

  state_e    state_q, state_d;
  op_class_e cls;
  logic      cond_pass;
  logic      base_wb;

  cond_eval u_cond_eval (
    .cond        (cond),
    .status_nzcv (status_nzcv),
    .pass        (cond_pass)
  );

  assign cls     = classify(opcode);
  assign base_wb = !opcode[2] || opcode[0];   // P=0 (post-index) or W=1

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    sel_pc       = SEL_PC_4;
    en_A         = 1'b0;
    en_B         = 1'b0;
    en_S         = 1'b0;
    en_C         = 1'b0;
    load_flags   = 1'b0;
    w_en_rf      = 1'b0;
    rf_dst_sel   = RF_DST_RD;
    wb_sel       = WB_ALU;
    waiting      = 1'b0;
    halted       = 1'b0;

    // Outputs are forced low while reset is held, so no request or write escapes.
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          waiting = 1'b1;
          if (start) begin
            load_pc = 1'b1;
            sel_pc  = SEL_PC_RST;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            load_ir = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          en_A = 1'b1;
          en_B = 1'b1;
          en_S = 1'b1;
          if (!cond_pass || cls == CLS_NOP) begin
            load_pc = 1'b1;
            state_d = ST_FETCH;
          end else if (cls == CLS_HALT) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          en_C = 1'b1;
          case (cls)
            CLS_ALU: begin
              load_flags = en_status;
              state_d    = ST_WB;
            end
            CLS_CMP: begin
              load_flags = 1'b1;
              load_pc    = 1'b1;
              state_d    = ST_FETCH;
            end
            CLS_B, CLS_BL, CLS_BX, CLS_BLX: begin
              load_pc = 1'b1;
              sel_pc  = (cls == CLS_BX || cls == CLS_BLX) ? SEL_PC_RM : SEL_PC_BR;
              state_d = ST_FETCH;
              if (cls == CLS_BL || cls == CLS_BLX) begin
                w_en_rf    = 1'b1;
                rf_dst_sel = RF_DST_LR;
                wb_sel     = WB_LINK;
              end
            end
            CLS_LDR, CLS_STR: state_d = ST_MEM;
            default: begin
              load_pc = 1'b1;
              state_d = ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls == CLS_STR);
          if (mem_ack) begin
            if (cls != CLS_STR) begin
              state_d = ST_WB;
            end else if (base_wb) begin
              state_d = ST_WB2;
            end else begin
              load_pc = 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_WB: begin
          w_en_rf = 1'b1;
          wb_sel  = (cls == CLS_LDR) ? WB_MEM : WB_ALU;
          if (cls == CLS_LDR && base_wb) begin
            state_d = ST_WB2;
          end else begin
            load_pc = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_WB2: begin
          w_en_rf    = 1'b1;
          rf_dst_sel = RF_DST_RN;
          load_pc    = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_HALT: halted = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
